// File: rtl/sm_result_fifo_pkg.sv
// Shared stack-machine definitions: result entry layout, status codes and
// the result-collector FSM encoding.
package sm_result_fifo_pkg;

    localparam int DATA_W  = 20;
    localparam int ERR_W   = 3;
    localparam int ENTRY_W = DATA_W + ERR_W;

    localparam logic [ERR_W-1:0] ERR_OK      = 3'd0;
    localparam logic [ERR_W-1:0] ERR_ERR     = 3'd1;
    localparam logic [ERR_W-1:0] ERR_UND     = 3'd2;
    localparam logic [ERR_W-1:0] ERR_RESTORE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sm_state_e;

    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [DATA_W-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/sm_res_buf.sv
// Circular result buffer: storage, read/write pointers and occupancy count.
// Callers must only pop when non-empty and only push when not full or popping.
module sm_res_buf
    import sm_result_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  res_entry_t               wr_entry,
    output res_entry_t               rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    res_entry_t    mem_q [DEPTH];
    res_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = wr_entry;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; only the bookkeeping clears.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_entry = mem_q[rptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_MAX);

endmodule

// File: rtl/sm_result_fifo.sv
// Collects stack-machine results into a FIFO, tracks accepted/error/dropped
// statistics and signals done once the program finished and the FIFO drained.
module sm_result_fifo
    import sm_result_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] out_data,
    input  logic [ERR_W-1:0]  err_code,
    input  logic              fin,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [ERR_W-1:0]  o_err,
    output logic              full,
    output logic              overflow,
    output logic [CW-1:0]     res_cnt,
    output logic [CW-1:0]     err_cnt,
    output logic [CW-1:0]     drop_cnt,
    output logic              done
);

    sm_state_e              state_q, state_d;
    logic [CW-1:0]          res_cnt_q, res_cnt_d;
    logic [CW-1:0]          err_cnt_q, err_cnt_d;
    logic [CW-1:0]          drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   push_req, push, pop, drop;
    logic [$clog2(DEPTH):0] count;
    res_entry_t             wr_entry, rd_entry;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    sm_res_buf #(.DEPTH(DEPTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fin) begin
                    state_d = ST_DRAIN;
                end else if (d_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fin) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((count == '0) && !push) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A push into a full buffer is still taken when the head leaves this cycle.
    always_comb begin
        done     = (state_q == ST_DONE);
        o_valid  = (count != '0);
        pop      = o_valid && o_ready;
        push_req = d_valid && (state_q != ST_DONE);
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_entry = '{err: err_code, data: out_data};
        o_data   = rd_entry.data;
        o_err    = rd_entry.err;
    end

    always_comb begin
        res_cnt_d  = res_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (push) begin
            res_cnt_d = sat_inc(res_cnt_q);
            if (err_code != ERR_OK) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            res_cnt_q  <= res_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign res_cnt  = res_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule
